// File: rtl/cla_pkg.sv
// Shared types and constants for the CLA self-test engine:
// FSM states, LFSR taps, corner vectors and LFSR step helper.
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    WAIT,
    CHECK
  } state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
  } vec_t;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  localparam logic [31:0] CORNER_A0 = 32'h0000_0000;
  localparam logic [31:0] CORNER_A1 = 32'hFFFF_FFFF;
  localparam logic [31:0] CORNER_A2 = 32'hFFFF_FFFF;
  localparam logic [31:0] CORNER_A3 = 32'h5555_5555;
  localparam logic [31:0] CORNER_B0 = 32'h0000_0000;
  localparam logic [31:0] CORNER_B1 = 32'h0000_0001;
  localparam logic [31:0] CORNER_B2 = 32'hFFFF_FFFF;
  localparam logic [31:0] CORNER_B3 = 32'hAAAA_AAAA;
  // bit i is the carry-in of corner vector i
  localparam logic [3:0]  CORNER_CIN = 4'b1100;

  localparam int unsigned NUM_CORNERS = 4;

  // right-shift Galois step
  function automatic logic [31:0] lfsr_next(
    input logic [31:0] q
  );
    return {1'b0, q[31:1]} ^ (q[0] ? LFSR_TAPS : 32'h0);
  endfunction

  function automatic vec_t corner_vec(
    input logic [1:0] i
  );
    vec_t v;
    v = '0;
    unique case (i)
      2'd0: v = '{CORNER_A0, CORNER_B0, CORNER_CIN[0]};
      2'd1: v = '{CORNER_A1, CORNER_B1, CORNER_CIN[1]};
      2'd2: v = '{CORNER_A2, CORNER_B2, CORNER_CIN[2]};
      2'd3: v = '{CORNER_A3, CORNER_B3, CORNER_CIN[3]};
    endcase
    return v;
  endfunction

endpackage

// File: rtl/cla_test_engine_lfsr32.sv
// cla_lfsr32: 32-bit Galois LFSR with seed load and double step.
// Ports: clk, rst (sync, high), load, step, seed[31:0], q[31:0].
module cla_lfsr32
  import cla_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] seed,
  output logic [31:0] q
);

  // one vector consumes two LFSR steps, so step advances twice
  always_ff @(posedge clk) begin
    if (rst || load) begin
      q <= seed;
    end else if (step) begin
      q <= lfsr_next(lfsr_next(q));
    end
  end

endmodule

// File: rtl/cla_test_engine.sv
// Self-test engine for a WIDTH-bit carry-lookahead adder: drives
// corner then LFSR vectors on a/b/cin, checks {cout,s} (and G/P
// when CLA_GP_CHECK_EN is defined), reports busy/done/pass,
// err_count, vec_count and first_fail_idx. Sync active-high rst.
module cla_test_engine
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned NUM_VECTORS = 256,
  parameter int unsigned LATENCY     = 0,
  parameter logic [31:0] SEED        = 32'hACE1_0001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             cin,
  input  logic [WIDTH-1:0] s,
  input  logic             cout,
  input  logic [WIDTH-1:0] G,
  input  logic [WIDTH-1:0] P,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [15:0]      vec_count,
  output logic [15:0]      first_fail_idx
);

  localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);
  localparam logic [2:0]  LAT_M1   = 3'(LATENCY - 1);
  localparam logic [15:0] NONE     = 16'hFFFF;

  state_t      state;
  state_t      nxt;
  logic [2:0]  wcnt;
  logic [15:0] idx;
  logic [15:0] nidx;
  logic [31:0] lq;
  logic [31:0] s1;
  logic [31:0] s2;
  logic        lload;
  logic        lstep;
  logic        use_corner;
  vec_t        nv;
  logic [WIDTH:0] gold;
  logic        gp_bad;
  logic        mism;
  logic        last;
  logic        unused_bits;

  cla_lfsr32 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (lload),
    .step (lstep),
    .seed (SEED),
    .q    (lq)
  );

  assign s1 = lfsr_next(lq);
  assign s2 = lfsr_next(s1);

  assign last = (idx == LAST_IDX);
  assign busy = (state != IDLE);

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (start) nxt = DRIVE;
      DRIVE: nxt = (LATENCY > 0) ? WAIT : CHECK;
      WAIT:  if (wcnt == LAT_M1) nxt = CHECK;
      CHECK: nxt = last ? IDLE : DRIVE;
      default: nxt = IDLE;
    endcase
  end

  // index of the vector about to be driven
  assign nidx = (state == CHECK) ? idx + 16'd1 : 16'd0;
  assign use_corner = (nidx < 16'(NUM_CORNERS));

  always_comb begin
    nv = '0;
    unique case (1'b1)
      use_corner: nv = corner_vec(nidx[1:0]);
      default:    nv = '{s1, s2, s2[31]};
    endcase
  end

  assign lload = (state == IDLE) && start;
  // LFSR only moves when it actually supplies a vector
  assign lstep = (state == CHECK) && !last
              && !use_corner;

  assign gold = {1'b0, a} + {1'b0, b}
              + {{WIDTH{1'b0}}, cin};

`ifdef CLA_GP_CHECK_EN
  assign gp_bad = (G != (a & b)) || (P != (a ^ b));
  assign unused_bits = ^{nv, s1, s2};
`else
  assign gp_bad = 1'b0;
  assign unused_bits = ^{nv, s1, s2, G, P};
`endif

  assign mism = ({cout, s} != gold) || gp_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      a              <= '0;
      b              <= '0;
      cin            <= 1'b0;
      wcnt           <= '0;
      idx            <= '0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      vec_count      <= '0;
      first_fail_idx <= NONE;
    end else begin
      state <= nxt;
      done  <= 1'b0;
      if (lload) begin
        err_count      <= '0;
        vec_count      <= '0;
        pass           <= 1'b0;
        first_fail_idx <= NONE;
      end
      if (nxt == DRIVE) begin
        idx  <= nidx;
        a    <= nv.a[WIDTH-1:0];
        b    <= nv.b[WIDTH-1:0];
        cin  <= nv.cin;
        wcnt <= '0;
      end
      if (state == WAIT) begin
        wcnt <= wcnt + 3'd1;
      end
      if (state == CHECK) begin
        vec_count <= vec_count + 16'd1;
        if (mism) begin
          if (err_count != NONE) begin
            err_count <= err_count + 16'd1;
          end
          if (first_fail_idx == NONE) begin
            first_fail_idx <= idx;
          end
        end
        if (last) begin
          done <= 1'b1;
          pass <= (err_count == 16'd0) && !mism;
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_test_engine.sv
// Directed bench for cla_test_engine: two instances (W8/N16/L0
// and W8/N4/L3) against a behavioural adder with fault controls.
module tb_cla_test_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start1 = 1'b0;
  logic start2 = 1'b0;
  logic stuck_s0 = 1'b0;
  logic force_por = 1'b0;

  logic [7:0]  a1, b1, s1, g1, p1;
  logic        cin1, cout1, busy1, done1, pass1;
  logic [15:0] err1, vec1, ffi1;
  logic [8:0]  sum1;

  logic [7:0]  a2, b2, s2, g2, p2;
  logic        cin2, cout2, busy2, done2, pass2;
  logic [15:0] err2, vec2, ffi2;
  logic [8:0]  sum2;

  int tests = 0;
  int fails = 0;

  logic [7:0] ra[64], rb[64], rs[64];
  logic       rc[64], rco[64];
  logic [7:0] ga[64], gb[64];
  logic       gc[64];

  logic [16:0] cexp[4] = '{
    {8'h00, 8'h00, 1'b0},
    {8'hFF, 8'h01, 1'b0},
    {8'hFF, 8'hFF, 1'b1},
    {8'h55, 8'hAA, 1'b1}
  };

  assign sum1  = {1'b0, a1} + {1'b0, b1} + {8'd0, cin1};
  assign s1    = sum1[7:0] & {7'h7F, ~stuck_s0};
  assign cout1 = sum1[8];
  assign g1    = a1 & b1;
  assign p1    = force_por ? (a1 | b1) : (a1 ^ b1);

  assign sum2  = {1'b0, a2} + {1'b0, b2} + {8'd0, cin2};
  assign s2    = sum2[7:0];
  assign cout2 = sum2[8];
  assign g2    = a2 & b2;
  assign p2    = a2 ^ b2;

  cla_test_engine #(
    .WIDTH(8), .NUM_VECTORS(16), .LATENCY(0)
  ) dut (
    .clk(clk), .rst(rst), .start(start1),
    .a(a1), .b(b1), .cin(cin1),
    .s(s1), .cout(cout1), .G(g1), .P(p1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .vec_count(vec1),
    .first_fail_idx(ffi1)
  );

  cla_test_engine #(
    .WIDTH(8), .NUM_VECTORS(4), .LATENCY(3)
  ) dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .a(a2), .b(b2), .cin(cin2),
    .s(s2), .cout(cout2), .G(g2), .P(p2),
    .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .vec_count(vec2),
    .first_fail_idx(ffi2)
  );

  always #5 clk = ~clk;

  // pulse start on dut, record one entry per busy cycle;
  // repulse_at re-asserts start, stop_at leaves mid-run
  task automatic run1(
    input  int repulse_at,
    input  int stop_at,
    output int cyc,
    output bit ok
  );
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    cyc = 0;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (busy1 && cyc < 64) begin
        ra[cyc] = a1; rb[cyc] = b1; rc[cyc] = cin1;
        rs[cyc] = s1; rco[cyc] = cout1;
        cyc++;
      end
      if (done1) begin
        ok = 1'b1;
        break;
      end
      if (cyc == stop_at) begin
        ok = 1'b1;
        break;
      end
      start1 = (cyc == repulse_at);
      @(negedge clk);
    end
    start1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({busy1, done1, pass1} !== 3'b000) begin
      fails++;
      $display("FAIL reset_flags got %b want 000",
               {busy1, done1, pass1});
    end
    tests++;
    if ({err1, vec1, ffi1} !== {16'd0, 16'd0, 16'hFFFF}) begin
      fails++;
      $display("FAIL reset_counts got %h %h %h want 0 0 ffff",
               err1, vec1, ffi1);
    end
    tests++;
    if ({a1, b1, cin1} !== 17'd0) begin
      fails++;
      $display("FAIL reset_abc got %h %h %b want 0",
               a1, b1, cin1);
    end
    tests++;
    if ({busy2, ffi2} !== {1'b0, 16'hFFFF}) begin
      fails++;
      $display("FAIL reset_dut2 got %b %h want 0 ffff",
               busy2, ffi2);
    end
    rst = 1'b0;
  endtask

  task automatic test_golden_run();
    int cyc;
    bit ok;
    run1(-1, -1, cyc, ok);
    tests++;
    if (!ok || cyc != 32) begin
      fails++;
      $display("FAIL golden_busy got %0d done=%b want 32",
               cyc, ok);
    end
    tests++;
    if ({err1, vec1, ffi1, pass1}
        !== {16'd0, 16'd16, 16'hFFFF, 1'b1}) begin
      fails++;
      $display("FAIL golden_result got %h %h %h %b want 0 10 ffff 1",
               err1, vec1, ffi1, pass1);
    end
    for (int i = 0; i < 64; i++) begin
      ga[i] = ra[i]; gb[i] = rb[i]; gc[i] = rc[i];
    end
    @(negedge clk);
    tests++;
    if (done1 !== 1'b0 || pass1 !== 1'b1) begin
      fails++;
      $display("FAIL done_pulse got done=%b pass=%b want 0 1",
               done1, pass1);
    end
  endtask

  task automatic test_corner_vectors();
    for (int k = 0; k < 4; k++) begin
      tests++;
      if ({ga[2*k], gb[2*k], gc[2*k]} !== cexp[k]) begin
        fails++;
        $display("FAIL corner%0d got %h %h %b want %h",
                 k, ga[2*k], gb[2*k], gc[2*k], cexp[k]);
      end
    end
    tests++;
    if ({rs[2], rco[2]} !== {8'h00, 1'b1}) begin
      fails++;
      $display("FAIL v1_sum got %h %b want 00 1",
               rs[2], rco[2]);
    end
    tests++;
    if ({ga[8], gb[8], gc[8]} !== {8'h03, 8'h02, 1'b1}) begin
      fails++;
      $display("FAIL lfsr_v4 got %h %h %b want 03 02 1",
               ga[8], gb[8], gc[8]);
    end
    tests++;
    if ({ga[10], gb[10], gc[10]} !== {8'h01, 8'h03, 1'b1}) begin
      fails++;
      $display("FAIL lfsr_v5 got %h %h %b want 01 03 1",
               ga[10], gb[10], gc[10]);
    end
  endtask

  task automatic test_stuck_s0();
    int cyc;
    bit ok;
    stuck_s0 = 1'b1;
    run1(-1, -1, cyc, ok);
    stuck_s0 = 1'b0;
    tests++;
    if (!ok || ffi1 !== 16'd2) begin
      fails++;
      $display("FAIL stuck_ffi got %h done=%b want 0002",
               ffi1, ok);
    end
    tests++;
    if (err1 === 16'd0 || pass1 !== 1'b0) begin
      fails++;
      $display("FAIL stuck_err got err=%h pass=%b want >0 0",
               err1, pass1);
    end
    tests++;
    if (vec1 !== 16'd16) begin
      fails++;
      $display("FAIL stuck_vec got %h want 0010", vec1);
    end
  endtask

  task automatic test_latency();
    logic [16:0] rec[64];
    int cyc;
    bit ok;
    int bad;
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    cyc = 0;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (busy2 && cyc < 64) begin
        rec[cyc] = {a2, b2, cin2};
        cyc++;
      end
      if (done2) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    tests++;
    if (!ok || cyc != 20) begin
      fails++;
      $display("FAIL lat_busy got %0d done=%b want 20", cyc, ok);
    end
    for (int k = 0; k < 4; k++) begin
      bad = 0;
      for (int j = 0; j < 5; j++) begin
        if (rec[5*k+j] !== cexp[k]) bad++;
      end
      tests++;
      if (bad != 0) begin
        fails++;
        $display("FAIL lat_window%0d got %0d unstable want 0",
                 k, bad);
      end
    end
    tests++;
    if ({err2, vec2, pass2} !== {16'd0, 16'd4, 1'b1}) begin
      fails++;
      $display("FAIL lat_result got %h %h %b want 0 4 1",
               err2, vec2, pass2);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [16:0] xv[8];
    int cyc;
    bit ok;
    run1(-1, 15, cyc, ok);
    for (int k = 0; k < 8; k++) begin
      xv[k] = {ra[2*k], rb[2*k], rc[2*k]};
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({busy1, done1, pass1, a1, b1, cin1} !== 20'd0) begin
      fails++;
      $display("FAIL midrst_out got %b %b %b %h %h %b want 0",
               busy1, done1, pass1, a1, b1, cin1);
    end
    tests++;
    if ({err1, vec1, ffi1} !== {16'd0, 16'd0, 16'hFFFF}) begin
      fails++;
      $display("FAIL midrst_cnt got %h %h %h want 0 0 ffff",
               err1, vec1, ffi1);
    end
    rst = 1'b0;
    run1(-1, -1, cyc, ok);
    for (int k = 0; k < 8; k++) begin
      tests++;
      if ({ra[2*k], rb[2*k], rc[2*k]} !== xv[k]) begin
        fails++;
        $display("FAIL repro_v%0d got %h want %h", k,
                 {ra[2*k], rb[2*k], rc[2*k]}, xv[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit ok;
    int diff;
    run1(5, -1, cyc, ok);
    tests++;
    if (!ok || cyc != 32) begin
      fails++;
      $display("FAIL repulse_busy got %0d done=%b want 32",
               cyc, ok);
    end
    diff = 0;
    for (int i = 0; i < 32; i++) begin
      if ({ra[i], rb[i], rc[i]} !== {ga[i], gb[i], gc[i]})
        diff++;
    end
    tests++;
    if (diff != 0) begin
      fails++;
      $display("FAIL rerun_seq got %0d diffs want 0", diff);
    end
    tests++;
    if ({err1, vec1, pass1} !== {16'd0, 16'd16, 1'b1}) begin
      fails++;
      $display("FAIL rerun_result got %h %h %b want 0 10 1",
               err1, vec1, pass1);
    end
  endtask

  task automatic test_gp();
    int cyc;
    bit ok;
    force_por = 1'b1;
    run1(-1, -1, cyc, ok);
    force_por = 1'b0;
`ifdef CLA_GP_CHECK_EN
    tests++;
    if (!ok || err1 === 16'd0 || ffi1 !== 16'd1) begin
      fails++;
      $display("FAIL gp_check got err=%h ffi=%h want >0 0001",
               err1, ffi1);
    end
`else
    tests++;
    if (!ok || err1 !== 16'd0 || pass1 !== 1'b1) begin
      fails++;
      $display("FAIL gp_ignored got err=%h pass=%b want 0 1",
               err1, pass1);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_golden_run();
    test_corner_vectors();
    test_stuck_s0();
    test_latency();
    test_reset_mid_run();
    test_back_to_back();
    test_gp();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cla_test_engine.md
CLA_TEST_ENGINE -- requirements
Module: cla_test_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand width; legal range 4..32.
REQ-002 SHALL have parameter NUM_VECTORS, default 256, giving the number of vectors per run; legal range 1..65535.
REQ-003 SHALL have parameter LATENCY, default 0, giving the DUT wait cycles between drive and check; legal range 0..7.
REQ-004 SHALL have parameter SEED, default 32'hACE1_0001, giving the LFSR seed (nonzero).
REQ-005 SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port start, input, 1 bit: run request, sampled in IDLE only.
REQ-008 SHALL have output ports a and b, WIDTH bits each: operands driven to the adder.
REQ-009 SHALL have output port cin, 1 bit: carry-in driven to the adder.
REQ-010 SHALL have input port s, WIDTH bits: adder sum.
REQ-011 SHALL have input port cout, 1 bit: adder carry-out.
REQ-012 SHALL have input ports G and P, WIDTH bits each: adder generate/propagate vectors.
REQ-013 SHALL have output port busy, 1 bit: run in progress.
REQ-014 SHALL have output port done, 1 bit: one-cycle pulse at end of run.
REQ-015 SHALL have output port pass, 1 bit: last run had zero mismatches.
REQ-016 SHALL have output port err_count, 16 bits: mismatching vectors this run, saturating.
REQ-017 SHALL have output port vec_count, 16 bits: vectors checked this run.
REQ-018 SHALL have output port first_fail_idx, 16 bits: index of first failing vector, 16'hFFFF if none.

Function
REQ-019 SHALL implement FSM states IDLE, DRIVE, WAIT, CHECK; IDLE->DRIVE on start; DRIVE->WAIT if LATENCY>0 else CHECK; WAIT->CHECK after LATENCY cycles; CHECK->DRIVE if more vectors remain else IDLE.
REQ-020 SHALL take exactly NUM_VECTORS*(LATENCY+2) busy cycles per run; busy high in DRIVE/WAIT/CHECK only.
REQ-021 SHALL register a/b/cin on entry to DRIVE and hold them stable through CHECK.
REQ-022 SHALL drive fixed corner vectors 0..3: (0,0,0); (all-ones,1,0); (all-ones,all-ones,1); (0x55..55,0xAA..AA,1), truncated to WIDTH.
REQ-023 SHALL drive vectors >=4 from a 32-bit Galois LFSR (taps 32'h8020_0003) advanced twice per vector: a = low WIDTH bits of step 1, b = low WIDTH bits of step 2, cin = bit 31 of step 2.
REQ-024 SHALL use NUM_VECTORS<4 to run only the first NUM_VECTORS corner vectors.
REQ-025 SHALL in CHECK compare {cout,s} against the (WIDTH+1)-bit value a+b+cin; a mismatch increments err_count (saturating at 16'hFFFF) and loads first_fail_idx if it is still 16'hFFFF.
REQ-026 SHALL increment vec_count once per CHECK.
REQ-027 SHALL pulse done for the cycle in which the FSM returns from the last CHECK to IDLE, and set pass = (err_count==0) in that same cycle.
REQ-028 SHALL clear err_count, vec_count, pass and first_fail_idx (to 16'hFFFF) and reload the LFSR with SEED on every accepted start.
REQ-029 SHALL ignore start while busy; results hold in IDLE until the next start.

Reset
REQ-030 SHALL, on rst high at a clock edge, enter IDLE and set a=b=0, cin=0, busy=0, done=0, pass=0, err_count=0, vec_count=0, first_fail_idx=16'hFFFF, LFSR=SEED, abandoning any run in progress.
REQ-031 SHALL give rst priority over start in the same cycle.

Configuration
REQ-032 SHALL support macro CLA_GP_CHECK_EN: when defined, CHECK additionally requires G==(a&b) and P==(a^b) for a pass; when undefined, G and P are unused and only {cout,s} is checked.

Structure
REQ-033 SHALL place the FSM state enum, LFSR taps constant and corner-vector constants in shared package cla_pkg.
REQ-034 SHALL instantiate one sub-module, cla_lfsr32 (seed load, step enable, 32-bit state output).

Verification
REQ-035 SHALL cover: golden behavioural adder, WIDTH=8, NUM_VECTORS=16, LATENCY=0, pulse start -> done after exactly 32 busy cycles, err_count=0, vec_count=16, pass=1, first_fail_idx=16'hFFFF.
REQ-036 SHALL cover: WIDTH=8, vector 1 -> a=8'hFF, b=8'h01, cin=0, with golden s=8'h00, cout=1 counted as pass.
REQ-037 SHALL cover: DUT with s[0] stuck-at-0 -> vector 2 (8'hFF+8'hFF+1, s=8'hFF) fails, first_fail_idx=2, err_count>0, pass=0.
REQ-038 SHALL cover: LATENCY=3, NUM_VECTORS=4 -> busy for 20 cycles and a/b/cin stable across each 5-cycle vector window.
REQ-039 SHALL cover: rst asserted at vector 7 -> next cycle IDLE with all outputs at reset values; a subsequent start reproduces identical a/b sequence from vector 0.
REQ-040 SHALL cover: start re-pulsed while busy -> ignored, run length unchanged; with CLA_GP_CHECK_EN and P forced to a|b -> err_count>0.
